// File: rtl/divider_pkg.sv
// Shared constants and types for the sequential restoring divider.
package divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quotient reported for a zero divisor.
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: trial subtract, keep the difference or restore.
// Purely combinational; the caller registers the results every cycle.
module divider_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   partial,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic             borrow;
  logic [WIDTH:0]   diff;
  logic             unused_diff_msb;

  assign {borrow, diff} = {1'b0, partial} - {2'b00, divisor};
  assign q_bit          = ~borrow;
  // A kept difference is below the divisor, so its top bit is always zero.
  assign next_rem        = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
  assign unused_diff_msb = diff[WIDTH];

endmodule

// File: rtl/divider.sv
// Restoring divider, one quotient bit per clock; signed mode when DIVIDER_SIGNED_EN is defined.
// Latency: done pulses WIDTH+1 cycles after the accepting edge; start is ignored unless IDLE and done is low.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_orig_q;
  logic             dbz_q;
  logic             accept;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] res_quo, res_rem;

`ifdef DIVIDER_SIGNED_EN
  logic dvd_neg, dvs_neg;
  logic q_neg_q, r_neg_q, ovf_q;
  logic ovf_in;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;
  assign ovf_in  = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign dvd_mag          = dividend;
  assign dvs_mag          = divisor;
`endif

  assign busy = (state == BUSY);

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        // The done cycle itself never accepts; the next start lands one cycle later.
        if (start && !done) begin
          next_state = BUSY;
          accept     = 1'b1;
        end
      end
      BUSY: begin
        if (cnt == LAST_CNT) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  divider_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .partial  ({rem_q, quo_q[WIDTH-1]}),
    .divisor  (dvs_q),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  always_comb begin
    res_quo = quo_q;
    res_rem = rem_q;
`ifdef DIVIDER_SIGNED_EN
    if (ovf_q) begin
      res_quo = {1'b1, {(WIDTH-1){1'b0}}};
      res_rem = '0;
    end else begin
      if (q_neg_q) res_quo = -quo_q;
      if (r_neg_q) res_rem = -rem_q;
    end
`endif
    // Zero divisor reports all-ones and the raw dividend bits at any WIDTH.
    if (dbz_q) begin
      res_quo = {WIDTH{DBZ_QUOTIENT[0]}};
      res_rem = dvd_orig_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_orig_q  <= '0;
      dbz_q       <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state <= next_state;
      done  <= 1'b0;
      if (accept) begin
        cnt        <= '0;
        rem_q      <= '0;
        quo_q      <= dvd_mag;
        dvs_q      <= dvs_mag;
        dvd_orig_q <= dividend;
        dbz_q      <= (divisor == '0);
`ifdef DIVIDER_SIGNED_EN
        q_neg_q    <= dvd_neg ^ dvs_neg;
        r_neg_q    <= dvd_neg;
        ovf_q      <= ovf_in;
`endif
      end else if (state == BUSY) begin
        cnt   <= cnt + 1'b1;
        rem_q <= step_rem;
        quo_q <= {quo_q[WIDTH-2:0], step_q};
      end else if (state == DONE) begin
        quotient    <= res_quo;
        remainder   <= res_rem;
        div_by_zero <= dbz_q;
        done        <= 1'b1;
      end
    end
  end

endmodule

// File: doc/divider.md
# divider

Sequential 32-bit integer divider producing quotient and remainder by restoring shift-subtract, one quotient bit per clock. It is the inverse-direction counterpart to the datapath adder and sits beside the ALU as a multi-cycle execution unit for div/divu. The control unit stalls on `busy` and writes HI/LO from `remainder`/`quotient` when `done` pulses.

## Interface
- `WIDTH`, default 32: operand and result width in bits.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset_n`  input  1: reset, asynchronous and active-low.
- `start`  input  1: request a division; accepted only in IDLE.
- `is_signed`  input  1: treat operands as two's complement; sampled with `start`.
- `dividend`  input  WIDTH: numerator; sampled on the accepting edge.
- `divisor`  input  WIDTH: denominator; sampled on the accepting edge.
- `busy`  output  1: high while a division is in progress (BUSY state).
- `done`  output  1: one-cycle pulse when results become valid.
- `quotient`  output  WIDTH: registered quotient.
- `remainder`  output  WIDTH: registered remainder.
- `div_by_zero`  output  1: registered flag; set with `done` when the divisor was 0.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY on the edge where `start`=1. Operands, `is_signed` and the result signs are latched, and the iteration counter is cleared.
- Signed mode: operands are converted to magnitudes. The quotient is negated when the operand signs differ. The remainder takes the sign of the dividend, giving truncation toward zero.
- BUSY: each cycle, shift {rem, quo} left by one and trial-subtract the divisor magnitude from the upper WIDTH+1 bits. If there is no borrow, keep the difference and set the new quotient LSB to 1. Otherwise restore and set it to 0.
- The counter is $clog2(WIDTH)+1 bits wide. BUSY -> DONE after exactly WIDTH iterations.
- DONE: apply sign correction, register the outputs, assert `done` for one cycle, then go to IDLE.
- Divide by zero: `quotient` = all ones, `remainder` = dividend (original, unsigned bit pattern), `div_by_zero`=1. The latency is unchanged.
- Signed overflow (dividend = most-negative value, divisor = -1): `quotient` = most-negative value, `remainder` = 0, `div_by_zero`=0.
- `start` while BUSY or DONE is ignored. Operand changes after acceptance have no effect.
- `quotient`, `remainder` and `div_by_zero` hold their values from `done` until the next accepted `start`, then keep those values until the next `done`.

## Timing
- Reset (`reset_n`=0, any time, including mid-division): state becomes IDLE immediately. `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, and the counter is cleared.
- `start` sampled at edge E0 (IDLE) -> `busy`=1 from E0 through E0+WIDTH.
- `done`=1 in the cycle after edge E0+WIDTH+1, so results are readable WIDTH+1 cycles after the accepting edge (33 for WIDTH=32).
- `busy` and `done` are never high together.
- Back-to-back operation: a `start` asserted while `done`=1 is ignored. The earliest accepted start is the cycle after `done`.

## Configuration
- `DIVIDER_SIGNED_EN`:
  - Defined: signed mode as described; `is_signed` is honoured.
  - Undefined: `is_signed` is ignored, all operations are unsigned, and the sign-correction and overflow logic is not synthesized. Divide-by-zero behaviour is unchanged.

## Structure
- Package `divider_pkg`: the `WIDTH` default constant, the state enum typedef (IDLE, BUSY, DONE), and the divide-by-zero quotient constant (all ones).
- Sub-module `divider_step`: combinational WIDTH+1-bit trial subtraction. It returns the next partial remainder and the quotient bit, and is instantiated once in the top.

## Test plan
- Unsigned: 100 / 7, `is_signed`=0 -> after 33 cycles `done` pulses; quotient=14, remainder=2, `div_by_zero`=0.
- Signed: -7 / 2 -> quotient=-3 (0xFFFFFFFD), remainder=-1 (0xFFFFFFFF). Then 7 / -2 -> quotient=-3, remainder=1.
- Divide by zero: 0x12345678 / 0 -> quotient=0xFFFFFFFF, remainder=0x12345678, `div_by_zero`=1, still at 33 cycles.
- Overflow: 0x80000000 / 0xFFFFFFFF, signed -> quotient=0x80000000, remainder=0. The same operands unsigned -> quotient=0, remainder=0x80000000.
- Start during BUSY: start 50/5, pulse `start` with 9/3 at cycle 10 -> a single `done`; quotient=10, remainder=0. Operands held from the first start.
- Reset mid-operation: drop `reset_n` at cycle 15 -> `busy`, `done` and all results are 0 immediately. After release, 9/4 yields quotient=2, remainder=1 in 33 cycles.
